imul_resp_accum: RTL and testbench

Downstream consumer of the iterative integer multiplier's response stream. It accepts a configured run length N, then absorbs exactly N 32-bit products over a val/rdy stream and sums them. It emits one 32-bit sum, plus a sticky unsigned-overflow flag, over a val/rdy output. It turns the multiplier into a dot-product engine without changing the multiplier.

---
 rtl/imul_resp_accum.sv | 126 ++++++++++++
 tb/tb_imul_resp_accum.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/imul_resp_accum.sv
// imul_resp_accum
//   Sums a configured number N of products from the iterative multiplier's
//   response stream. It emits one NBITS-wide sum and a sticky unsigned-overflow
//   flag. With it, the multiplier works as a dot-product engine.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   cfg_*    val/rdy run-length request (cfg_msg = N, unsigned)
//   in_*     val/rdy product stream (from multiplier resp_*)
//   out_*    val/rdy sum response (out_msg = sum mod 2^NBITS, out_ovf = carry seen)
//   busy     high whenever not idle
module imul_resp_accum #(
    parameter int unsigned NBITS = 32,
    parameter int unsigned LBITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_val,
    output logic             cfg_rdy,
    input  logic [LBITS-1:0] cfg_msg,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_msg,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [LBITS-1:0] len_q, len_d;
    logic [LBITS-1:0] cnt_q, cnt_d;

    logic             cfg_fire, in_fire, out_fire;
    logic [NBITS:0]   sum;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sum      = {1'b0, acc_q} + {1'b0, in_msg};
        cfg_fire = cfg_val && cfg_rdy;
        in_fire  = in_val && in_rdy;
        out_fire = out_val && out_rdy;

        case (state_q)
            IDLE: begin
                if (cfg_fire) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    len_d   = cfg_msg;
                    state_d = (cfg_msg != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (in_fire) begin
                    acc_d = sum[NBITS-1:0];
                    ovf_d = ovf_q | sum[NBITS];
                    cnt_d = cnt_q + LBITS'(1);
                    if (cnt_d == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // cfg_rdy in DONE already requires out_rdy, so a cfg fire here
                // always coincides with an out fire: the next run starts with
                // no idle cycle in between.
                if (out_fire) begin
                    if (cfg_fire) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                        len_d   = cfg_msg;
                        state_d = (cfg_msg != '0) ? ACCUM : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; handshakes are forced low while reset is held
    always_comb begin
        cfg_rdy = reset && ((state_q == IDLE) || ((state_q == DONE) && out_rdy));
        in_rdy  = reset && (state_q == ACCUM);
        out_val = reset && (state_q == DONE);
        out_msg = acc_q;
        out_ovf = ovf_q;
        busy    = (state_q != IDLE);
    end

endmodule

// File: tb/tb_imul_resp_accum.sv
module tb_imul_resp_accum;

    logic        clk;
    logic        reset;
    logic        cfg_val;
    logic        cfg_rdy;
    logic [15:0] cfg_msg;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_msg;
    logic        out_ovf;
    logic        busy;

    int unsigned nvec;
    int unsigned nerr;

    imul_resp_accum #(.NBITS(32), .LBITS(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .cfg_val (cfg_val),
        .cfg_rdy (cfg_rdy),
        .cfg_msg (cfg_msg),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg),
        .out_ovf (out_ovf),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned       n;
        logic [3:0][31:0]  p;
        logic [31:0]       exp_sum;
        logic              exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Configure a run of n products and feed them. With rnd set, in_val is
    // toggled randomly, otherwise held high. Stops when out_val is seen.
    // With rel set, the result is consumed afterwards.
    task automatic run(input string tag, input int unsigned n, input logic [3:0][31:0] p,
                       input logic [31:0] es, input logic eo, input bit rnd, input bit rel);
        int unsigned cyc;
        int unsigned k;
        bit          fire;
        bit          saw_in_rdy;
        check({tag, " cfg_rdy before cfg"}, 32'(cfg_rdy), 32'd1);
        cfg_val = 1'b1;
        cfg_msg = 16'(n);
        step();
        cfg_val = 1'b0;
        cyc = 1;
        k = 0;
        saw_in_rdy = 1'b0;
        while (!out_val && cyc < 200) begin
            if (in_rdy) saw_in_rdy = 1'b1;
            in_val = (k < n) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            in_msg = (k < 4) ? p[k] : 32'hDEAD_BEEF;
            fire = in_val && in_rdy;
            step();
            if (fire) k++;
            cyc++;
        end
        in_val = 1'b0;
        check({tag, " out_val"}, 32'(out_val), 32'd1);
        check({tag, " products consumed"}, k, n);
        if (!rnd) check({tag, " cfg-to-out_val cycles"}, cyc, n + 1);
        check({tag, " in_rdy seen"}, 32'(saw_in_rdy), 32'(n != 0));
        check({tag, " out_msg"}, out_msg, es);
        check({tag, " out_ovf"}, 32'(out_ovf), 32'(eo));
        check({tag, " in_rdy in DONE"}, 32'(in_rdy), 32'd0);
        if (rel) begin
            out_rdy = 1'b1;
            step();
            out_rdy = 1'b0;
            check({tag, " out_val after fire"}, 32'(out_val), 32'd0);
            check({tag, " busy after fire"}, 32'(busy), 32'd0);
            check({tag, " sum held in IDLE"}, out_msg, es);
        end
    endtask

    initial begin
        logic [3:0][31:0] pp;
        nvec = 0;
        nerr = 0;

        vecs[0] = '{n: 3, p: {32'd0, 32'd4, 32'd3, 32'd2}, exp_sum: 32'd9, exp_ovf: 1'b0};
        vecs[1] = '{n: 2, p: {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF}, exp_sum: 32'd1, exp_ovf: 1'b1};
        vecs[2] = '{n: 1, p: {32'd0, 32'd0, 32'd0, 32'd5}, exp_sum: 32'd5, exp_ovf: 1'b0};
        vecs[3] = '{n: 0, p: {32'd0, 32'd0, 32'd0, 32'd0}, exp_sum: 32'd0, exp_ovf: 1'b0};
        vecs[4] = '{n: 4, p: {32'd2, 32'd1, 32'h8000_0000, 32'h8000_0000}, exp_sum: 32'd3, exp_ovf: 1'b1};
        vecs[5] = '{n: 4, p: {32'd40, 32'd30, 32'd20, 32'd10}, exp_sum: 32'd100, exp_ovf: 1'b0};

        reset   = 1'b0;
        cfg_val = 1'b0;
        cfg_msg = '0;
        in_val  = 1'b0;
        in_msg  = '0;
        out_rdy = 1'b0;

        #12;
        check("reset cfg_rdy", 32'(cfg_rdy), 32'd0);
        check("reset in_rdy", 32'(in_rdy), 32'd0);
        check("reset out_val", 32'(out_val), 32'd0);
        check("reset out_msg", out_msg, 32'd0);
        check("reset out_ovf", 32'(out_ovf), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        step();
        reset = 1'b1;
        step();
        check("post-reset cfg_rdy", 32'(cfg_rdy), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run($sformatf("vec%0d", i), vecs[i].n, vecs[i].p, vecs[i].exp_sum,
                vecs[i].exp_ovf, 1'b0, 1'b1);
        end

        // Back-pressure: random in_val, then out_rdy held low for 5 cycles
        pp = {32'd1, 32'd10, 32'hFFFF_FFFE, 32'd7};
        run("bp", 4, pp, 32'h10, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp stall%0d out_val", i), 32'(out_val), 32'd1);
            check($sformatf("bp stall%0d out_msg", i), out_msg, 32'h10);
            check($sformatf("bp stall%0d out_ovf", i), 32'(out_ovf), 32'd1);
            step();
        end

        // Back-to-back: out fire and cfg fire in the same cycle
        out_rdy = 1'b1;
        cfg_val = 1'b1;
        cfg_msg = 16'd1;
        #1;
        check("b2b cfg_rdy in DONE", 32'(cfg_rdy), 32'd1);
        step();
        out_rdy = 1'b0;
        cfg_val = 1'b0;
        check("b2b in_rdy next cycle", 32'(in_rdy), 32'd1);
        check("b2b out_val dropped", 32'(out_val), 32'd0);
        in_val = 1'b1;
        in_msg = 32'h1234;
        step();
        in_val = 1'b0;
        check("b2b out_val", 32'(out_val), 32'd1);
        check("b2b out_msg", out_msg, 32'h1234);
        check("b2b out_ovf cleared", 32'(out_ovf), 32'd0);
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;

        // Reset mid-run after two products
        cfg_val = 1'b1;
        cfg_msg = 16'd5;
        step();
        check("mid cfg_rdy in ACCUM", 32'(cfg_rdy), 32'd0);
        cfg_val = 1'b0;
        in_val  = 1'b1;
        in_msg  = 32'd100;
        step();
        in_msg  = 32'd23;
        step();
        in_val  = 1'b0;
        check("mid partial sum", out_msg, 32'd123);
        check("mid busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid rst cfg_rdy", 32'(cfg_rdy), 32'd0);
        check("mid rst in_rdy", 32'(in_rdy), 32'd0);
        check("mid rst out_val", 32'(out_val), 32'd0);
        check("mid rst out_msg", out_msg, 32'd0);
        check("mid rst out_ovf", 32'(out_ovf), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        step();
        reset = 1'b1;
        step();
        check("mid post-reset cfg_rdy", 32'(cfg_rdy), 32'd1);
        check("mid post-reset out_val", 32'(out_val), 32'd0);
        pp = {32'd0, 32'd0, 32'd0, 32'd6};
        run("fresh", 1, pp, 32'd6, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
